// File: rtl/game_pkg.sv
// Shared game-flow types and constants for the level sequencer.
// Background palette lookup is kept here so every consumer agrees.
package game_pkg;

    localparam int LEVEL_W = 2;
    localparam int LIVES_W = 2;
    localparam int TIMER_W = 8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PLAY       = 3'd1,
        HIT_HOLD   = 3'd2,
        LEVEL_DONE = 3'd3,
        GAME_OVER  = 3'd4,
        WIN        = 3'd5
    } game_state_t;

    localparam logic [3:0] BG_TABLE [4] = '{4'hF, 4'hA, 4'h6, 4'h3};

    function automatic logic [3:0] bg_of(input logic [LEVEL_W-1:0] lvl);
        return BG_TABLE[lvl];
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter with zero flag; stops at zero.
// Shared by both hold states of the level sequencer.
module frame_timer
    import game_pkg::*;
(
    input  logic               frame_clk,
    input  logic               reset,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge frame_clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (count != '0)
            count <= count - 1'b1;
    end

    assign zero = (count == '0);

endmodule

// File: rtl/level_controller.sv
// Frame-rate game-flow sequencer: respawn, obstacle restart,
// level progression, lives and background selection.
module level_controller
    import game_pkg::*;
#(
    parameter int           NUM_LEVELS  = 3,
    parameter int           LIVES_INIT  = 3,
    parameter logic [9:0]   FINISH_X    = 10'd588,
    parameter logic [7:0]   HOLD_FRAMES = 8'd60
) (
    input  logic         frame_clk,
    input  logic         reset,
    input  logic         start,
    input  logic [9:0]   ball_x,
    input  logic [2:0]   hit,
    output logic [1:0]   current_level,
    output logic [3:0]   background,
    output logic         reset_player,
    output logic         reset_obstacles,
    output logic [1:0]   lives,
    output logic         game_over,
    output logic         game_won
);

    localparam logic [LEVEL_W-1:0] LAST_LVL  = LEVEL_W'(NUM_LEVELS - 1);
    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
    localparam logic [TIMER_W-1:0] HOLD_LOAD =
        (HOLD_FRAMES == 8'd0) ? 8'd0 : HOLD_FRAMES - 8'd1;

    game_state_t        state, state_n;
    logic [LEVEL_W-1:0] level_n;
    logic [LIVES_W-1:0] lives_n;
    logic               t_load;
    logic [TIMER_W-1:0] t_count;
    logic               t_zero;

    frame_timer u_timer (
        .frame_clk (frame_clk),
        .reset     (reset),
        .load      (t_load),
        .load_val  (HOLD_LOAD),
        .count     (t_count),
        .zero      (t_zero)
    );

    always_comb begin
        state_n = state;
        level_n = current_level;
        lives_n = lives;
        t_load  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = PLAY;
            end
            PLAY: begin
                // A hit outranks reaching the finish line in the same frame.
                if (hit != 3'b000) begin
                    if (lives <= 2'd1) begin
                        state_n = GAME_OVER;
                        lives_n = '0;
                    end else begin
                        state_n = HIT_HOLD;
                        lives_n = lives - 1'b1;
                        t_load  = 1'b1;
                    end
                end else if (ball_x >= FINISH_X) begin
                    if (current_level >= LAST_LVL) begin
                        state_n = WIN;
                    end else begin
                        state_n = LEVEL_DONE;
                        level_n = current_level + 1'b1;
                        t_load  = 1'b1;
                    end
                end
            end
            HIT_HOLD, LEVEL_DONE: begin
                if (t_zero)
                    state_n = PLAY;
            end
            GAME_OVER, WIN: begin
                if (start) begin
                    state_n = IDLE;
                    level_n = '0;
                    lives_n = LIVES_RST;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge frame_clk) begin
        if (reset) begin
            state           <= IDLE;
            current_level   <= '0;
            background      <= bg_of('0);
            lives           <= LIVES_RST;
            reset_player    <= 1'b1;
            reset_obstacles <= 1'b1;
            game_over       <= 1'b0;
            game_won        <= 1'b0;
        end else begin
            state           <= state_n;
            current_level   <= level_n;
            background      <= bg_of(level_n);
            lives           <= lives_n;
            reset_player    <= (state_n != PLAY);
            reset_obstacles <= (state_n != PLAY) && (state_n != HIT_HOLD);
            game_over       <= (state_n == GAME_OVER);
            game_won        <= (state_n == WIN);
        end
    end

endmodule

// File: tb/tb_level_controller.sv
// Directed plus random frames checked against a behavioural game model.
module tb_level_controller;

    logic       frame_clk;
    logic       reset;
    logic       start;
    logic [9:0] ball_x;
    logic [2:0] hit;
    logic [1:0] current_level;
    logic [3:0] background;
    logic       reset_player;
    logic       reset_obstacles;
    logic [1:0] lives;
    logic       game_over;
    logic       game_won;

    level_controller dut (
        .frame_clk       (frame_clk),
        .reset           (reset),
        .start           (start),
        .ball_x          (ball_x),
        .hit             (hit),
        .current_level   (current_level),
        .background      (background),
        .reset_player    (reset_player),
        .reset_obstacles (reset_obstacles),
        .lives           (lives),
        .game_over       (game_over),
        .game_won        (game_won)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    int total = 0;
    int bad   = 0;

    // Behavioural model: phase name, level, lives, frames left in a hold.
    localparam int HOLD = 60;
    localparam int FIN  = 588;
    int    m_level;
    int    m_lives;
    int    m_left;
    string m_phase;
    int    bg_tab [4] = '{15, 10, 6, 3};

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d (phase %s)",
                   tag, obs, exp, m_phase);
        end
    endtask

    task automatic check_all();
        bit playing;
        bit obst_held;
        playing   = (m_phase == "play");
        obst_held = !(playing || m_phase == "hit");
        chk("level", int'(current_level), m_level);
        chk("bg", int'(background), bg_tab[m_level]);
        chk("lives", int'(lives), m_lives);
        chk("reset_player", int'(reset_player), playing ? 0 : 1);
        chk("reset_obst", int'(reset_obstacles), obst_held ? 1 : 0);
        chk("game_over", int'(game_over), m_phase == "over" ? 1 : 0);
        chk("game_won", int'(game_won), m_phase == "won" ? 1 : 0);
    endtask

    task automatic model_frame(input bit s, input int bx, input int h);
        if (m_phase == "idle") begin
            if (s) m_phase = "play";
        end else if (m_phase == "play") begin
            if (h != 0) begin
                if (m_lives == 1) begin
                    m_lives = 0;
                    m_phase = "over";
                end else begin
                    m_lives = m_lives - 1;
                    m_phase = "hit";
                    m_left  = HOLD;
                end
            end else if (bx >= FIN) begin
                if (m_level == 2) begin
                    m_phase = "won";
                end else begin
                    m_level = m_level + 1;
                    m_phase = "clear";
                    m_left  = HOLD;
                end
            end
        end else if (m_phase == "hit" || m_phase == "clear") begin
            m_left = m_left - 1;
            if (m_left == 0) m_phase = "play";
        end else if (s) begin
            m_phase = "idle";
            m_level = 0;
            m_lives = 3;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge frame_clk);
        #1;
        m_phase = "idle";
        m_level = 0;
        m_lives = 3;
        m_left  = 0;
        check_all();
        reset = 1'b0;
    endtask

    task automatic step(input bit s, input int bx, input int h);
        start  = s;
        ball_x = 10'(bx);
        hit    = 3'(h);
        @(posedge frame_clk);
        #1;
        model_frame(s, bx, h);
        check_all();
    endtask

    task automatic idle_frames(input int n);
        for (int i = 0; i < n; i++) step(0, 100, 0);
    endtask

    initial begin
        reset  = 1'b1;
        start  = 1'b0;
        ball_x = '0;
        hit    = '0;
        m_phase = "idle";
        m_level = 0;
        m_lives = 3;
        m_left  = 0;
        do_reset();
        idle_frames(2);
        step(1, 100, 0);
        step(0, 100, 1);
        idle_frames(62);
        step(0, 588, 0);
        idle_frames(62);
        step(0, 600, 4);
        idle_frames(62);
        step(0, 300, 2);
        idle_frames(3);
        step(1, 300, 0);
        idle_frames(2);
        step(1, 100, 0);
        step(0, 587, 0);
        step(0, 588, 0);
        idle_frames(60);
        step(0, 1023, 0);
        idle_frames(60);
        step(0, 590, 0);
        idle_frames(3);
        step(0, 590, 7);
        step(1, 100, 0);
        step(1, 100, 0);
        step(0, 100, 1);
        idle_frames(10);
        step(1, 100, 1);
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            bit s;
            int bx;
            int h;
            s  = ($urandom_range(0, 15) == 0);
            bx = ($urandom_range(0, 30) == 0)
                 ? int'($urandom_range(580, 1023))
                 : int'($urandom_range(0, 600));
            h  = ($urandom_range(0, 40) == 0)
                 ? int'($urandom_range(1, 7)) : 0;
            if ($urandom_range(0, 500) == 0)
                do_reset();
            else
                step(s, bx, h);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
